cardinal_fetch_unit: RTL and testbench
======================================

Name: cardinal_fetch_unit

Overview:
Parametrised instruction-fetch front end for the cardinal pipeline.
- Replaces the single IF_ID register with a DEPTH-entry prefetch queue.
- Issues sequential fetches to a 1-cycle-latency instruction memory.
- Hands instructions and their PCs to decode over a valid/ready handshake.
- Supports zero-bubble redirect (branch/flush) that squashes queued and in-flight fetches.

Parameters:
ADDR_W, 8, instruction address / PC width
INSTR_W, 32, instruction width
DEPTH, 4, prefetch queue entries; power of two, >= 2

Ports:
Clock  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
Imem_En  out  1  fetch request this cycle
Instr_Addr  out  ADDR_W  fetch address
Instruction  in  INSTR_W  imem read data, valid the cycle after an Imem_En request
Redirect  in  1  branch taken / flush request
Redirect_Addr  in  ADDR_W  redirect target
Out_Valid  out  1  Out_Instr/Out_PC valid
Out_Ready  in  1  decode accepts the entry
Out_Instr  out  INSTR_W  head-of-queue instruction
Out_PC  out  ADDR_W  address of Out_Instr
Occupancy  out  $clog2(DEPTH+1)  valid queue entries

Behaviour:
- Clock is Clock; reset is Reset, synchronous, active-high.
- Reset values:
  - PC = 0; queue empty; in-flight flag = 0.
  - Outputs: Imem_En = 0, Out_Valid = 0, Occupancy = 0.
  - Out_Instr and Out_PC = 0.
- Reset mid-operation discards all queued and in-flight data.
- Latency:
  - A request issued in cycle N returns Instruction in N+1, which is written into the queue at the end of N+1.
  - Out_Valid for that entry rises in N+2. There is no bypass.
- pop = Out_Valid && Out_Ready.
- Issue rule (credit scheme): Imem_En = !Reset && (Redirect || (Occupancy + inflight - pop < DEPTH)).
  - The queue therefore never overflows.
  - An overflow is a bench assertion failure.
- Normal issue: Instr_Addr = PC; PC <= PC + 1.
- PC wraps modulo 2^ADDR_W (all-ones -> 0).
- Each in-flight request carries its address. The response is pushed as {Instruction, addr}.
- Redirect cycle:
  - Instr_Addr = Redirect_Addr combinationally; Imem_En = 1.
  - PC <= Redirect_Addr + 1.
  - Queue cleared; in-flight response squashed (not pushed next cycle).
  - Out_Valid forced 0, so pop = 0 regardless of Out_Ready.
- Redirect has priority over pop, push and normal issue.
- First instruction at the redirect target reaches Out_Valid two cycles after the redirect cycle.
- Consecutive redirects: each redirect squashes the previous target's in-flight fetch. Only the last target is delivered.
- Simultaneous push and pop: Occupancy unchanged; the queue must accept both in the same cycle, including when full.
- Out_Ready = 0 with full credit: Imem_En = 0. PC and the queue hold.
- Out_Ready = 1 steady state: one instruction per cycle, no gaps, including after a stall is released.
- Out_Instr and Out_PC hold the head entry while Out_Valid = 1 and Out_Ready = 0.

Decomposition:
- cardinal_pkg holds:
  - default ADDR_W and INSTR_W
  - the NOP encoding (111100 in bits [0:5]), used by the bench as filler
  - a fetch-entry struct {instr, pc}
- Sub-module cardinal_sync_fifo (WIDTH, DEPTH) provides:
  - push, pop and clear, with clear taking priority
  - count output
  - wrap-around pointers with an extra MSB to distinguish full from empty
  - same-cycle push and pop when full

Test Plan:
1. Release Reset with Out_Ready = 1 and mem[i] = i -> Instr_Addr 0,1,2,... from the first cycle. Out_Valid rises 2 cycles later with PC 0; then one entry per cycle with PC = Instr = 0,1,2,...
2. Hold Out_Ready = 0 with DEPTH = 4 -> exactly 4 requests (addresses 0..3), then Imem_En = 0 and Occupancy = 4. Raise Out_Ready -> PCs 0,1,2,3,4,5 with no bubble.
3. Assert Redirect to 0x40 while Occupancy = 3 and a fetch is in flight -> that cycle Out_Valid = 0, Instr_Addr = 0x40. Old entries never appear; PC 0x40 appears 2 cycles later, then 0x41.
4. Redirect to 0xFF -> delivered PCs are 0xFF then 0x00 (wrap).
5. Redirect to 0x10, then to 0x20 in the next cycle -> no 0x10 entry is delivered; the first output PC is 0x20.
6. Assert Reset for one cycle with a full queue -> the next cycle has Out_Valid = 0 and Occupancy = 0. Fetching restarts at address 0 and the stale response is not pushed.

Source files
------------

// File: rtl/cardinal_pkg.sv
// Shared widths, NOP encoding and fetch-entry record for the cardinal front end.
// Pure declarations: no latency or backpressure of its own.
package cardinal_pkg;

   localparam int CARD_ADDR_W  = 8;
   localparam int CARD_INSTR_W = 32;

   // Opcode field is listed MSB-first as [0:5], so bit 0 of the word carries the leading 1.
   localparam logic [0:5] NOP_OPCODE = 6'b111100;

   typedef struct packed {
      logic [CARD_INSTR_W-1:0] instr;
      logic [CARD_ADDR_W-1:0]  pc;
   } fetch_entry_t;

   function automatic logic [CARD_INSTR_W-1:0] nop_instr();
      logic [CARD_INSTR_W-1:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[i] = NOP_OPCODE[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/cardinal_sync_fifo.sv
// Synchronous FIFO with clear; pop data is the registered head, visible with zero latency.
// Push when full is accepted only together with a pop; clear overrides push and pop.
module cardinal_sync_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_dat,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign count   = wr_ptr_q - rd_ptr_q;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge Clock) begin
      if (Reset || clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset && !clear && do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
      end
   end

endmodule

// File: rtl/cardinal_fetch_unit.sv
// Prefetch front end: sequential fetch into a DEPTH-entry queue; issue-to-Out_Valid is 2 cycles.
// Issue is credit-limited by queue space; Redirect squashes everything and refetches at once.
module cardinal_fetch_unit
   import cardinal_pkg::*;
#(
   parameter int ADDR_W  = CARD_ADDR_W,
   parameter int INSTR_W = CARD_INSTR_W,
   parameter int DEPTH   = 4
) (
   input  logic                         Clock,
   input  logic                         Reset,
   output logic                         Imem_En,
   output logic [ADDR_W-1:0]            Instr_Addr,
   input  logic [INSTR_W-1:0]           Instruction,
   input  logic                         Redirect,
   input  logic [ADDR_W-1:0]            Redirect_Addr,
   output logic                         Out_Valid,
   input  logic                         Out_Ready,
   output logic [INSTR_W-1:0]           Out_Instr,
   output logic [ADDR_W-1:0]            Out_PC,
   output logic [$clog2(DEPTH+1)-1:0]   Occupancy
);

   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] inflight_addr_q;
   logic              inflight_q;
   logic              push;
   logic              pop;
   logic              empty;
   logic [CW-1:0]     count;
   logic [CW:0]       credit;
   entry_t            push_dat;
   entry_t            head;

   assign Out_Valid = !empty && !Redirect && !Reset;
   assign pop       = Out_Valid && Out_Ready;
   assign push      = inflight_q && !Redirect;
   assign push_dat  = '{instr: Instruction, pc: inflight_addr_q};

   // Queued plus in-flight entries, less the one leaving now, must stay below DEPTH.
   assign credit     = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign Imem_En    = !Reset && (Redirect || (credit < (CW+1)'(DEPTH)));
   assign Instr_Addr = Redirect ? Redirect_Addr : pc_q;

   assign Out_Instr = empty ? '0 : head.instr;
   assign Out_PC    = empty ? '0 : head.pc;
   assign Occupancy = count;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc_q            <= '0;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
      end else begin
         inflight_q <= Imem_En;
         if (Imem_En) inflight_addr_q <= Instr_Addr;
         if (Redirect)     pc_q <= Redirect_Addr + ADDR_W'(1);
         else if (Imem_En) pc_q <= pc_q + ADDR_W'(1);
      end
   end

   cardinal_sync_fifo #(
      .WIDTH (INSTR_W + ADDR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .Clock    (Clock),
      .Reset    (Reset),
      .clear    (Redirect),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .pop_dat  (head),
      .count    (count),
      .empty    (empty)
   );

endmodule

// File: tb/tb_cardinal_fetch_unit.sv
// Directed bench for cardinal_fetch_unit: per-cycle vector table plus reset and streaming sequences.
module tb_cardinal_fetch_unit;
   import cardinal_pkg::*;

   localparam int AW = 8;
   localparam int IW = 32;
   localparam int D  = 4;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          Imem_En;
   logic [AW-1:0] Instr_Addr;
   logic [IW-1:0] Instruction = '0;
   logic          Redirect = 1'b0;
   logic [AW-1:0] Redirect_Addr = '0;
   logic          Out_Valid;
   logic          Out_Ready = 1'b0;
   logic [IW-1:0] Out_Instr;
   logic [AW-1:0] Out_PC;
   logic [2:0]    Occupancy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rst;
      logic       rdy;
      logic       rd;
      logic [7:0] rda;
      logic       en;
      logic [7:0] addr;
      logic       vld;
      logic [7:0] pc;
      logic [2:0] occ;
   } vec_t;

   vec_t vecs[$];

   cardinal_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D)) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .Imem_En       (Imem_En),
      .Instr_Addr    (Instr_Addr),
      .Instruction   (Instruction),
      .Redirect      (Redirect),
      .Redirect_Addr (Redirect_Addr),
      .Out_Valid     (Out_Valid),
      .Out_Ready     (Out_Ready),
      .Out_Instr     (Out_Instr),
      .Out_PC        (Out_PC),
      .Occupancy     (Occupancy)
   );

   always #5 Clock = ~Clock;

   // Instruction memory holds mem[i] = i; idle cycles return NOP filler.
   always @(posedge Clock) begin
      Instruction <= Imem_En ? {24'b0, Instr_Addr} : nop_instr();
   end

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic rdy, input logic rd, input logic [7:0] rda,
                      input logic en, input logic [7:0] addr, input logic vld, input logic [7:0] pc,
                      input logic [2:0] occ);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rd = rd; v.rda = rda;
      v.en = en; v.addr = addr; v.vld = vld; v.pc = pc; v.occ = occ;
      vecs.push_back(v);
   endtask

   task automatic drive(input int row, input logic rst, input logic rdy, input logic rd, input logic [7:0] rda);
      @(negedge Clock);
      Reset = rst; Out_Ready = rdy; Redirect = rd; Redirect_Addr = rda;
      #1;
      chk("no_overflow", row, {31'b0, dut.push && !dut.pop && (Occupancy == 3'd4)}, 32'd0);
   endtask

   task automatic check_row(input int row, input vec_t v);
      chk("imem_en", row, {31'b0, Imem_En}, {31'b0, v.en});
      if (v.en) chk("instr_addr", row, {24'b0, Instr_Addr}, {24'b0, v.addr});
      chk("out_valid", row, {31'b0, Out_Valid}, {31'b0, v.vld});
      if (!v.rst) chk("occupancy", row, {29'b0, Occupancy}, {29'b0, v.occ});
      if (v.vld || (!v.rst && v.occ == 3'd0)) begin
         chk("out_pc", row, {24'b0, Out_PC}, {24'b0, v.pc});
         chk("out_instr", row, Out_Instr, {24'b0, v.pc});
      end
   endtask

   initial begin
      // rst rdy rd rda    en addr   vld pc     occ
      add(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00, 1);
      add(0, 1, 0, 8'h00, 1, 8'h03, 1, 8'h01, 1);
      add(0, 1, 0, 8'h00, 1, 8'h04, 1, 8'h02, 1);
      // stall with Out_Ready low from a fresh reset
      add(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
      add(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
      add(0, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 0);
      add(0, 0, 0, 8'h00, 1, 8'h02, 1, 8'h00, 1);
      add(0, 0, 0, 8'h00, 1, 8'h03, 1, 8'h00, 2);
      add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 3);
      add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 4);
      add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 4);
      add(0, 1, 0, 8'h00, 1, 8'h04, 1, 8'h00, 4);
      add(0, 1, 0, 8'h00, 1, 8'h05, 1, 8'h01, 3);
      add(0, 1, 0, 8'h00, 1, 8'h06, 1, 8'h02, 3);
      add(0, 1, 0, 8'h00, 1, 8'h07, 1, 8'h03, 3);
      add(0, 1, 0, 8'h00, 1, 8'h08, 1, 8'h04, 3);
      add(0, 1, 0, 8'h00, 1, 8'h09, 1, 8'h05, 3);
      // redirect to 0x40 with three queued and one in flight
      add(0, 1, 1, 8'h40, 1, 8'h40, 0, 8'h00, 3);
      add(0, 1, 0, 8'h00, 1, 8'h41, 0, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 8'h42, 1, 8'h40, 1);
      add(0, 1, 0, 8'h00, 1, 8'h43, 1, 8'h41, 1);
      // redirect to 0xFF, PC wraps
      add(0, 1, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, 1);
      add(0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 8'h01, 1, 8'hFF, 1);
      add(0, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00, 1);
      // back-to-back redirects: only 0x20 survives
      add(0, 1, 1, 8'h10, 1, 8'h10, 0, 8'h00, 1);
      add(0, 1, 1, 8'h20, 1, 8'h20, 0, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 8'h21, 0, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 8'h22, 1, 8'h20, 1);
      add(0, 1, 0, 8'h00, 1, 8'h23, 1, 8'h21, 1);
      // fill the queue, then reset it
      add(0, 0, 0, 8'h00, 1, 8'h24, 1, 8'h22, 1);
      add(0, 0, 0, 8'h00, 1, 8'h25, 1, 8'h22, 2);
      add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h22, 3);
      add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h22, 4);
      add(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00, 0);
      add(0, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00, 1);

      @(posedge Clock);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(i, vecs[i].rst, vecs[i].rdy, vecs[i].rd, vecs[i].rda);
         check_row(i, vecs[i]);
      end

      // Reset while a response is in flight: the stale response must not land in the queue.
      drive(100, 1, 0, 0, 8'h00);
      chk("rst_imem_en", 100, {31'b0, Imem_En}, 32'd0);
      chk("rst_out_valid", 100, {31'b0, Out_Valid}, 32'd0);
      drive(101, 0, 0, 0, 8'h00);
      chk("post_rst_occ", 101, {29'b0, Occupancy}, 32'd0);
      chk("post_rst_addr", 101, {24'b0, Instr_Addr}, 32'd0);
      drive(102, 0, 0, 0, 8'h00);
      chk("post_rst_occ2", 102, {29'b0, Occupancy}, 32'd0);
      chk("post_rst_vld2", 102, {31'b0, Out_Valid}, 32'd0);
      drive(103, 0, 0, 0, 8'h00);
      chk("post_rst_pc", 103, {24'b0, Out_PC}, 32'd0);
      chk("post_rst_occ3", 103, {29'b0, Occupancy}, 32'd1);

      // Stall released: one instruction per cycle with no gap.
      for (int k = 0; k < 20; k++) begin
         drive(200 + k, 0, 1, 0, 8'h00);
         chk("stream_vld", 200 + k, {31'b0, Out_Valid}, 32'd1);
         chk("stream_pc", 200 + k, {24'b0, Out_PC}, k);
         chk("stream_instr", 200 + k, Out_Instr, k);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
